// File: rtl/shift_pkg.sv
// Shared widths, direction encodings and the packed shift-command layout.
// No logic; constants and types only.
// Used by the shifter, the command FIFO and the queue top.
package shift_pkg;

    localparam int W     = 8;
    localparam int NW    = 3;
    localparam int CMD_W = W + 1 + NW;

    localparam logic SHIFT_LEFT  = 1'b0;
    localparam logic SHIFT_RIGHT = 1'b1;

    typedef struct packed {
        logic [W-1:0]  a;
        logic          d;
        logic [NW-1:0] n;
    } cmd_t;

endpackage

// File: rtl/shift.sv
// Logical barrel shifter, zero fill, left or right by 0..2**NW-1.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module shift
    import shift_pkg::*;
(
    input  logic [W-1:0]  a_i,
    input  logic          d_i,
    input  logic [NW-1:0] n_i,
    output logic [W-1:0]  x_o
);

    always_comb begin
        if (d_i == SHIFT_RIGHT) begin
            x_o = a_i >> n_i;
        end else begin
            x_o = a_i << n_i;
        end
    end

endmodule

// File: rtl/shift_cmd_fifo.sv
// Circular command FIFO with occupancy count; head entry is always visible.
// Latency: a push is visible at the head after one edge.
// Backpressure: caller must not push when full nor pop when empty.
module shift_cmd_fifo
    import shift_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = CMD_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [DW-1:0]            push_dat_i,
    input  logic                     pop_i,
    output logic [DW-1:0]            head_dat_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    // Pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_dat_i;
            end
        end
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign empty_o    = (count_q == '0);

endmodule

// File: rtl/shift_cmd_queue.sv
// Queued shifter: FIFO of commands, shifter on the head, registered valid/ready result.
// Latency: push at edge t into an empty queue gives out_valid after edge t+1; 1 cmd/cycle.
// Backpressure: in_ready = !full from registered count; result held while !out_ready.
// Optional SHIFT_LEVEL_EN adds the `level` occupancy port.
module shift_cmd_queue
    import shift_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [W-1:0]            in_a,
    input  logic                    in_d,
    input  logic [NW-1:0]           in_n,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [W-1:0]            out_x
`ifdef SHIFT_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0]  level
`endif
);

    cmd_t                   push_cmd;
    cmd_t                   head_cmd;
    logic                   push;
    logic                   ld;
    logic                   full;
    logic                   empty;
    logic [$clog2(DEPTH):0] count;
    logic [W-1:0]           shift_x;
    logic                   out_valid_q, out_valid_d;
    logic [W-1:0]           out_x_q, out_x_d;

    assign push_cmd = '{a: in_a, d: in_d, n: in_n};
    assign full     = (count == ($clog2(DEPTH)+1)'(DEPTH));
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign ld       = !empty && (!out_valid_q || out_ready);

    shift_cmd_fifo #(
        .DEPTH (DEPTH),
        .DW    (CMD_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push),
        .push_dat_i (push_cmd),
        .pop_i      (ld),
        .head_dat_o (head_cmd),
        .count_o    (count),
        .empty_o    (empty)
    );

    shift u_shift (
        .a_i (head_cmd.a),
        .d_i (head_cmd.d),
        .n_i (head_cmd.n),
        .x_o (shift_x)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        out_x_d     = out_x_q;
        if (ld) begin
            out_valid_d = 1'b1;
            out_x_d     = shift_x;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_x_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_x_q     <= out_x_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_x     = out_x_q;

`ifdef SHIFT_LEVEL_EN
    assign level = count;
`endif

endmodule

// File: tb/tb_shift_cmd_queue.sv
// Randomized and directed bench for shift_cmd_queue against a queue-based reference model.
// Checks reset, single commands, backpressure, streaming, mid-operation reset and level.
module tb_shift_cmd_queue;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic       in_d;
    logic [2:0] in_n;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_x;
`ifdef SHIFT_LEVEL_EN
    logic [2:0] level;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [11:0] mq[$];
    logic        mv;
    logic [7:0]  mx;

    always #5 clk = ~clk;

    shift_cmd_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_d      (in_d),
        .in_n      (in_n),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x)
`ifdef SHIFT_LEVEL_EN
        ,
        .level     (level)
`endif
    );

    function automatic logic [7:0] ref_shift(input logic [7:0] a, input logic d, input logic [2:0] n);
        logic [7:0] r;
        if (d) r = a >> n;
        else   r = a << n;
        return r;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        check_val("out_valid", 32'(out_valid), 32'(mv));
        check_val("out_x", 32'(out_x), 32'(mx));
        check_val("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
`ifdef SHIFT_LEVEL_EN
        check_val("level", 32'(level), 32'(mq.size()));
`endif
    endtask

    // One clock: check at negedge, drive, then advance the model at the rising edge.
    task automatic step(input logic v, input logic [7:0] a, input logic d,
                        input logic [2:0] n, input logic ordy, output logic acc);
        logic        push;
        logic        ld;
        logic [11:0] cmd;
        @(negedge clk);
        check_outputs();
        in_valid  = v;
        in_a      = a;
        in_d      = d;
        in_n      = n;
        out_ready = ordy;
        push = v && (mq.size() < DEPTH);
        ld   = (mq.size() > 0) && (!mv || ordy);
        @(posedge clk);
        if (ld) begin
            cmd = mq.pop_front();
            mx  = ref_shift(cmd[11:4], cmd[3], cmd[2:0]);
            mv  = 1'b1;
        end else if (mv && ordy) begin
            mv = 1'b0;
        end
        if (push) mq.push_back({a, d, n});
        acc = push;
    endtask

    task automatic idle(input int cycles, input logic ordy);
        logic acc;
        for (int i = 0; i < cycles; i++) step(1'b0, 8'h00, 1'b0, 3'd0, ordy, acc);
    endtask

    task automatic model_reset();
        mq.delete();
        mv = 1'b0;
        mx = 8'h00;
    endtask

    initial begin
        logic       acc;
        logic [7:0] first_res;
        logic [7:0] exp4 [8];
        logic [7:0] ra;
        logic       rd;
        logic [2:0] rn;

        // Reset with in_valid held high
        rst_n = 1'b0; in_valid = 1'b1; in_a = 8'hA5; in_d = 1'b0; in_n = 3'd1; out_ready = 1'b1;
        model_reset();
        #1;
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_out_x", 32'(out_x), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        idle(3, 1'b1);

        // Single commands
        step(1'b1, 8'h10, 1'b1, 3'd2, 1'b1, acc);
        idle(1, 1'b1);
        #1;
        check_val("s2_right", 32'(out_x), 32'h04);
        check_val("s2_right_vld", 32'(out_valid), 32'd1);
        step(1'b1, 8'h10, 1'b0, 3'd2, 1'b1, acc);
        idle(1, 1'b1);
        #1;
        check_val("s2_left", 32'(out_x), 32'h40);
        step(1'b1, 8'h00, 1'b0, 3'd0, 1'b1, acc);
        idle(1, 1'b1);
        #1;
        check_val("s2_zero", 32'(out_x), 32'h00);
        idle(2, 1'b1);

        // Backpressure: five pushes with the consumer stalled fill the queue
        first_res = 8'h00;
        for (int i = 0; i < 5; i++) begin
            ra = 8'($urandom); rd = 1'($urandom); rn = 3'($urandom);
            if (i == 0) first_res = ref_shift(ra, rd, rn);
            step(1'b1, ra, rd, rn, 1'b0, acc);
            check_val("s3_accept", 32'(acc), 32'd1);
        end
        #1;
        check_val("s3_full", 32'(in_ready), 32'd0);
        check_val("s3_frozen", 32'(out_x), 32'(first_res));
        step(1'b1, 8'hFF, 1'b0, 3'd1, 1'b0, acc);
        check_val("s3_stall", 32'(acc), 32'd0);
        #1;
        check_val("s3_still_frozen", 32'(out_x), 32'(first_res));
        idle(7, 1'b1);

        // Streaming 8'h81 with increasing left shifts
        exp4 = '{8'h81, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 8'h81, 1'b0, 3'(i), 1'b1, acc);
            #1;
            if (i > 0) check_val("s4_stream", 32'(out_x), 32'(exp4[i-1]));
`ifdef SHIFT_LEVEL_EN
            check_val("s4_level_le1", 32'(level <= 3'd1), 32'd1);
`endif
        end
        idle(1, 1'b1);
        #1;
        check_val("s4_last", 32'(out_x), 32'h80);
        idle(2, 1'b1);

        // Mid-operation reset with one result held and three queued
        for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom), 1'($urandom), 3'($urandom), 1'b0, acc);
        @(negedge clk);
        check_outputs();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_val("s5_out_valid", 32'(out_valid), 32'd0);
        check_val("s5_in_ready", 32'(in_ready), 32'd1);
        check_val("s5_out_x", 32'(out_x), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(4, 1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom), 8'($urandom), 1'($urandom), 3'($urandom),
                 ($urandom_range(0, 3) != 0), acc);
        end
        idle(8, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
